ifetch_unit: RTL
================

Name: ifetch_unit

Overview:
- Fetch-side consumer of the next-PC value.
- Holds the architectural fetch PC and issues instruction reads to instruction memory over a req/ack handshake.
- Buffers returned words in a small prefetch queue and hands {pc, inst} pairs to decode with valid/ready.
- A taken branch/JAL redirect from the PC control logic flushes the queue and any in-flight read, then restarts fetch at the new target.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset
- QDEPTH, 2, prefetch queue entries (power of two, >=2)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- redirect_valid  in  1  taken branch/JAL this cycle
- redirect_pc  in  32  new fetch target (Pc_nxt on taken branch/JAL)
- mem_req  out  1  instruction read request, registered
- mem_addr  out  32  read address, registered, word-aligned
- mem_ack  in  1  one-cycle pulse: mem_rdata valid, request complete
- mem_rdata  in  32  instruction word
- inst_valid  out  1  queue head valid
- inst_ready  in  1  decode accepts head
- inst  out  32  head instruction word
- inst_pc  out  32  address of head instruction

Behaviour:
- Reset (rst_n low at a rising edge):
  - fetch_pc=RESET_PC, queue empty, state=IDLE.
  - mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=RESET_PC.
  - Reset mid-request abandons the request; any ack arriving after reset while in IDLE is ignored.
- States: IDLE (no read outstanding), WAIT (read outstanding, result kept), DROP (read outstanding, result discarded).
- Issue rule:
  - In IDLE with occupancy < QDEPTH and no redirect this cycle, register mem_req=1, mem_addr=fetch_pc; go to WAIT.
  - Once raised, mem_req and mem_addr hold stable until the mem_ack cycle. Requests are never withdrawn.
- WAIT + mem_ack, no redirect:
  - Push {fetch_pc, mem_rdata}; fetch_pc+=4 (32-bit wrap, 0xFFFF_FFFC -> 0).
  - If room remains after the push (counting a same-cycle pop), the next request is registered in the same edge: mem_req stays 1 with the new address. Otherwise mem_req=0 and the state goes to IDLE.
  - Steady-state throughput is one instruction per ack.
- Redirect (any state):
  - fetch_pc <= {redirect_pc[31:2],2'b00}; queue flushed, so inst_valid=0 next cycle.
  - A pop handshaked in the redirect cycle counts as consumed.
  - IDLE, or WAIT with mem_ack the same cycle: the read is complete and its data is dropped. mem_req=1, mem_addr=target at the next edge (1-cycle redirect-to-request latency).
  - WAIT without ack: go to DROP.
  - DROP: the target is overwritten by the newest redirect_pc; stay in DROP.
- DROP + mem_ack: discard data. Issue at target on the same edge (mem_req stays 1, address changes) -> WAIT.
- Queue:
  - Occupancy 0..QDEPTH; head drives inst/inst_pc.
  - Simultaneous push and pop when full is legal: occupancy is unchanged.
  - No push occurs when full, guaranteed by the issue rule counting the outstanding read.
  - When empty, inst/inst_pc hold their last values.
- inst_valid, inst and inst_pc stay stable while inst_valid=1 and inst_ready=0, except on a redirect flush.

Decomposition:
- Shared package cpu_pkg:
  - ifetch_state_t enum {IF_IDLE, IF_WAIT, IF_DROP}
  - INST_NOP = 32'h0000_0013
  - XLEN = 32
  - PC_STEP = 4
- One sub-module: ifetch_queue.
  - Sync FIFO with flush, width 64 ({pc, inst}), depth QDEPTH.
  - Ports: push, pop, flush, count, full, empty.
  - Flush has priority over push/pop.

Test Plan:
- Reset, ack every request after 1 cycle, inst_ready=1 -> inst_pc sequence 0x0, 0x4, 0x8, 0xC; mem_req never drops after the first issue.
- inst_ready=0 with 0-cycle-latency acks -> exactly QDEPTH=2 pushes (pc 0x0, 0x4), mem_req=0. Raise inst_ready -> fetch resumes at 0x8.
- Redirect to 0x0000_0103 while a read of 0x8 is outstanding:
  - mem_addr stays 0x8 until ack; that data is never presented.
  - Next mem_addr=0x100; first inst_pc=0x100.
- Redirect coincident with mem_ack, and two redirects (0x200, then 0x300) during DROP -> only 0x300 is fetched; queue is empty in between.
- fetch_pc=0xFFFF_FFFC, ack -> next mem_addr=0x0000_0000.
- rst_n low for 1 cycle while mem_req=1 -> mem_req=0 and inst_valid=0 after the edge; a stale ack is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end.
//   ifetch_state_t : fetch read-tracking states
//   INST_NOP       : instruction word shown before anything has been fetched
//   XLEN           : datapath / address width
//   PC_STEP        : byte distance between sequential instructions
package cpu_pkg;

    localparam int unsigned XLEN     = 32;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        IF_IDLE,
        IF_WAIT,
        IF_DROP
    } ifetch_state_t;

endpackage

// File: rtl/ifetch_queue.sv
// Prefetch FIFO holding {pc, inst} pairs between the fetch engine and decode.
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : empties the queue; wins over push/pop
//   push/push_data : write one entry (simultaneous push+pop when full is legal)
//   pop        : drop the head entry
//   head       : current head entry (stale when empty)
//   count/full/empty : occupancy status
module ifetch_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && do_push) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues reads to instruction
// memory over req/ack, buffers returned words and hands {pc, inst} to decode.
//   clk, rst_n                 : clock, synchronous active-low reset
//   redirect_valid/redirect_pc : taken branch/JAL target, flushes the front end
//   mem_req/mem_addr           : registered read request, held until mem_ack
//   mem_ack/mem_rdata          : one-cycle completion pulse with the word
//   inst_valid/inst_ready      : decode handshake
//   inst/inst_pc               : head instruction and its address
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    ifetch_state_t     state, state_n;
    logic [XLEN-1:0]   fetch_pc, fetch_pc_n;
    logic              mem_req_n;
    logic [XLEN-1:0]   mem_addr_n;
    logic [XLEN-1:0]   redirect_tgt;
    logic [XLEN-1:0]   pc_inc;
    logic [2*XLEN-1:0] q_head;
    logic [2*XLEN-1:0] last_head;
    logic [CW-1:0]     q_count;
    logic              q_full;
    logic              q_empty;
    logic              push;
    logic              pop;
    logic [CW:0]       occ_after;
    logic              room_after_push;

    assign redirect_tgt = redirect_pc & ~XLEN'(3);
    assign pc_inc       = fetch_pc + PC_STEP;
    assign inst_valid   = !q_empty;
    assign pop          = inst_valid && inst_ready;
    assign push         = (state == IF_WAIT) && mem_ack && !redirect_valid;

    // Room for one more outstanding read once this cycle's push/pop settle.
    assign occ_after       = (CW+1)'(q_count) + (CW+1)'(1) - (CW+1)'(pop);
    assign room_after_push = occ_after < (CW+1)'(QDEPTH);

    // An empty queue keeps presenting the last head seen.
    assign {inst_pc, inst} = q_empty ? last_head : q_head;

    ifetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (2*XLEN)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({fetch_pc, mem_rdata}),
        .pop       (pop),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        mem_req_n  = mem_req;
        mem_addr_n = mem_addr;
        case (state)
            IF_IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_n = redirect_tgt;
                    mem_req_n  = 1'b1;
                    mem_addr_n = redirect_tgt;
                    state_n    = IF_WAIT;
                end else if (!q_full) begin
                    mem_req_n  = 1'b1;
                    mem_addr_n = fetch_pc;
                    state_n    = IF_WAIT;
                end
            end
            IF_WAIT: begin
                if (redirect_valid) begin
                    fetch_pc_n = redirect_tgt;
                    if (mem_ack) mem_addr_n = redirect_tgt;
                    else         state_n    = IF_DROP;
                end else if (mem_ack) begin
                    fetch_pc_n = pc_inc;
                    if (room_after_push) begin
                        mem_addr_n = pc_inc;
                    end else begin
                        mem_req_n = 1'b0;
                        state_n   = IF_IDLE;
                    end
                end
            end
            IF_DROP: begin
                if (redirect_valid) fetch_pc_n = redirect_tgt;
                // Stale word returns: discard it and chase the newest target.
                if (mem_ack) begin
                    mem_addr_n = redirect_valid ? redirect_tgt : fetch_pc;
                    state_n    = IF_WAIT;
                end
            end
            default: state_n = IF_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IF_IDLE;
            fetch_pc  <= RESET_PC;
            mem_req   <= 1'b0;
            mem_addr  <= RESET_PC;
            last_head <= {RESET_PC, INST_NOP};
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            mem_req  <= mem_req_n;
            mem_addr <= mem_addr_n;
            if (!q_empty) last_head <= q_head;
        end
    end

endmodule
